// File: rtl/key_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// key_interrupt_sequencer
//
// Turns a keyboard event into a controlled interrupt of the fetch stage.
// A key event freezes the PC and fills F/D with bubbles until the pipeline
// has been free of mult/div work, stalls and resolving jumps for
// DRAIN_CYCLES consecutive cycles. A single `j HANDLER_ADDR` instruction is
// then injected. The handler runs until the decoder reports its return
// instruction, after which a one-cycle jump override sends fetch back to the
// interrupted PC. One further key event can be held while an interrupt is
// in progress; any more are counted as dropped.
//
// Parameters
//   HANDLER_ADDR  27-bit handler entry, target field of the injected jump
//   DRAIN_CYCLES  consecutive quiet cycles needed before injection (1..7)
//
// Ports
//   clock                  in   master clock, rising edge
//   reset                  in   asynchronous active-low reset
//   key_valid / key_code   in   key event strobe and its 8-bit scan code
//   pc_in                  in   current fetch PC
//   should_jump / jump_to  in   jump resolving this cycle and its target
//   muldiv_busy            in   mult/div in flight in F/D or D/X
//   stall_in               in   decode-stage stall
//   iret_seen              in   decoder saw the handler's return instruction
//   fetch_hold             out  freeze the PC
//   insert_nop             out  load a bubble into F/D
//   interrupt_instruction  out  injected instruction, 0 when not injecting
//   irq_active             out  handler is executing
//   key_data               out  scan code of the interrupt being serviced
//   resume_valid           out  one-cycle jump-override strobe
//   resume_pc              out  return target, valid with resume_valid
//   drop_count             out  saturating count of lost key events
// -----------------------------------------------------------------------------
module key_interrupt_sequencer #(
    parameter logic [26:0] HANDLER_ADDR = 27'd4000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    input  logic [31:0] pc_in,
    input  logic        should_jump,
    input  logic [31:0] jump_to,
    input  logic        muldiv_busy,
    input  logic        stall_in,
    input  logic        iret_seen,
    output logic        fetch_hold,
    output logic        insert_nop,
    output logic [31:0] interrupt_instruction,
    output logic        irq_active,
    output logic [7:0]  key_data,
    output logic        resume_valid,
    output logic [31:0] resume_pc,
    output logic [7:0]  drop_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        INJECT  = 3'd2,
        SERVICE = 3'd3,
        RESUME  = 3'd4
    } state_t;

    // The counter value seen in the last quiet cycle before injection.
    localparam logic [2:0] QUIET_LAST = 3'(DRAIN_CYCLES - 1);

    state_t      state;
    logic [31:0] saved_pc;
    logic [2:0]  quiet_cnt;
    logic        first_drain;
    logic        pending_valid;
    logic [7:0]  pending_code;
    logic        quiet;
    logic        take_key;

    // J-type encoding: opcode 5'b00001 followed by the 27-bit target.
    function automatic logic [31:0] jump_instr(input logic [26:0] target);
        return {5'b00001, target};
    endfunction

    // Decode of a quiet pipeline cycle and of an interrupt request in IDLE.
    always_comb begin
        quiet    = ~muldiv_busy & ~stall_in & ~should_jump;
        take_key = pending_valid | key_valid;
    end

    // Interrupt sequencing FSM; outputs are registered alongside the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            fetch_hold            <= 1'b0;
            insert_nop            <= 1'b0;
            interrupt_instruction <= 32'd0;
            irq_active            <= 1'b0;
            key_data              <= 8'd0;
            resume_valid          <= 1'b0;
            resume_pc             <= 32'd0;
            saved_pc              <= 32'd0;
            quiet_cnt             <= 3'd0;
            first_drain           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_key) begin
                        state       <= DRAIN;
                        fetch_hold  <= 1'b1;
                        insert_nop  <= 1'b1;
                        first_drain <= 1'b1;
                        quiet_cnt   <= 3'd0;
                        // The older, buffered key is always serviced first.
                        key_data    <= pending_valid ? pending_code : key_code;
                    end
                end
                DRAIN: begin
                    first_drain <= 1'b0;
                    // A resolving jump redirects the return point; it wins
                    // over the first-cycle PC capture.
                    if (should_jump) begin
                        saved_pc <= jump_to;
                    end else if (first_drain) begin
                        saved_pc <= pc_in;
                    end
                    if (quiet) begin
                        if (quiet_cnt == QUIET_LAST) begin
                            state                 <= INJECT;
                            insert_nop            <= 1'b0;
                            interrupt_instruction <= jump_instr(HANDLER_ADDR);
                            quiet_cnt             <= 3'd0;
                        end else begin
                            quiet_cnt <= quiet_cnt + 3'd1;
                        end
                    end else begin
                        quiet_cnt <= 3'd0;
                    end
                end
                INJECT: begin
                    state                 <= SERVICE;
                    fetch_hold            <= 1'b0;
                    interrupt_instruction <= 32'd0;
                    irq_active            <= 1'b1;
                end
                SERVICE: begin
                    if (iret_seen) begin
                        state        <= RESUME;
                        irq_active   <= 1'b0;
                        resume_valid <= 1'b1;
                        resume_pc    <= saved_pc;
                    end
                end
                RESUME: begin
                    state        <= IDLE;
                    resume_valid <= 1'b0;
                    resume_pc    <= 32'd0;
                end
                default: begin
                    state                 <= IDLE;
                    fetch_hold            <= 1'b0;
                    insert_nop            <= 1'b0;
                    interrupt_instruction <= 32'd0;
                    irq_active            <= 1'b0;
                    resume_valid          <= 1'b0;
                    resume_pc             <= 32'd0;
                    quiet_cnt             <= 3'd0;
                    first_drain           <= 1'b0;
                end
            endcase
        end
    end

    // One-entry key buffer and saturating drop counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_valid <= 1'b0;
            pending_code  <= 8'd0;
            drop_count    <= 8'd0;
        end else if (state == IDLE) begin
            // A buffered key is consumed now; a simultaneous new key takes
            // its place. Without a buffered key the new one is consumed
            // directly and the buffer stays empty.
            if (pending_valid) begin
                pending_valid <= key_valid;
                if (key_valid) begin
                    pending_code <= key_code;
                end
            end
        end else if (key_valid) begin
            if (!pending_valid) begin
                pending_valid <= 1'b1;
                pending_code  <= key_code;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for key_interrupt_sequencer.
// Cycle c of a scenario begins just after a rising edge: inputs for cycle c
// are driven #1 after that edge and outputs are sampled on the falling edge
// in the middle of cycle c.
// -----------------------------------------------------------------------------
module tb_key_interrupt_sequencer;

    localparam logic [31:0] INJ = 32'h0800_0FA0;
    localparam int          D   = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        key_valid, should_jump, muldiv_busy, stall_in, iret_seen;
    logic [7:0]  key_code;
    logic [31:0] pc_in, jump_to;
    logic        fetch_hold, insert_nop, irq_active, resume_valid;
    logic [31:0] interrupt_instruction, resume_pc;
    logic [7:0]  key_data, drop_count;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    key_interrupt_sequencer #(
        .HANDLER_ADDR(27'd4000),
        .DRAIN_CYCLES(D)
    ) dut (
        .clock(clock), .reset(reset),
        .key_valid(key_valid), .key_code(key_code), .pc_in(pc_in),
        .should_jump(should_jump), .jump_to(jump_to),
        .muldiv_busy(muldiv_busy), .stall_in(stall_in), .iret_seen(iret_seen),
        .fetch_hold(fetch_hold), .insert_nop(insert_nop),
        .interrupt_instruction(interrupt_instruction), .irq_active(irq_active),
        .key_data(key_data), .resume_valid(resume_valid), .resume_pc(resume_pc),
        .drop_count(drop_count)
    );

    task automatic quiet_inputs();
        key_valid   = 1'b0;
        key_code    = 8'd0;
        should_jump = 1'b0;
        jump_to     = 32'd0;
        muldiv_busy = 1'b0;
        stall_in    = 1'b0;
        iret_seen   = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        quiet_inputs();
        pc_in = 32'hFFFF_FFFF;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({fetch_hold, insert_nop, irq_active, resume_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got %b expected 0000", {fetch_hold, insert_nop, irq_active, resume_valid});
        end
        checks++;
        if ({interrupt_instruction, resume_pc, key_data, drop_count} !== 80'd0) begin
            failures++;
            $display("FAIL reset_data instr=%h rpc=%h key=%h drops=%h expected all 0",
                     interrupt_instruction, resume_pc, key_data, drop_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // One key at cycle 5 with optional busy window and jump; iret 10 cycles
    // after the expected injection.
    task automatic run_single(input string name, input logic [31:0] pc,
                              input int blo, input int bhi, input int jc,
                              input logic [31:0] jt, input int inj,
                              input logic [31:0] exp_rpc);
        int         iret = inj + 10;
        logic [3:0] exp_ctrl;
        do_reset();
        pc_in = pc;
        for (int c = 0; c <= iret + 3; c++) begin
            quiet_inputs();
            key_valid   = (c == 5);
            key_code    = 8'h1C;
            muldiv_busy = (c >= blo && c <= bhi);
            should_jump = (c == jc);
            jump_to     = jt;
            iret_seen   = (c == iret);
            @(negedge clock);
            exp_ctrl = {c >= 6 && c <= inj, c >= 6 && c < inj, c > inj && c <= iret, c == iret + 1};
            checks++;
            if ({fetch_hold, insert_nop, irq_active, resume_valid} !== exp_ctrl) begin
                failures++;
                $display("FAIL %s_ctrl cycle %0d got %b expected %b", name, c,
                         {fetch_hold, insert_nop, irq_active, resume_valid}, exp_ctrl);
            end
            checks++;
            if (interrupt_instruction !== ((c == inj) ? INJ : 32'd0)) begin
                failures++;
                $display("FAIL %s_instr cycle %0d got %h expected %h", name, c,
                         interrupt_instruction, (c == inj) ? INJ : 32'd0);
            end
            if (c == iret + 1) begin
                checks++;
                if (resume_pc !== exp_rpc) begin
                    failures++;
                    $display("FAIL %s_resume_pc got %h expected %h", name, resume_pc, exp_rpc);
                end
            end
            if (c == inj + 1) begin
                checks++;
                if (key_data !== 8'h1C) begin
                    failures++;
                    $display("FAIL %s_key_data got %h expected 1c", name, key_data);
                end
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_basic();
        run_single("basic", 32'd100, 1, 0, -1, 32'd0, 10, 32'd100);
    endtask

    task automatic test_muldiv_drain();
        run_single("muldiv", 32'd100, 6, 8, -1, 32'd0, 13, 32'd100);
    endtask

    task automatic test_jump_drain();
        run_single("jump", 32'd100, 1, 0, 8, 32'h200, 13, 32'h200);
    endtask

    task automatic test_queue_drop();
        logic [3:0] exp_ctrl;
        do_reset();
        pc_in = 32'h1234;
        for (int c = 0; c <= 30; c++) begin
            quiet_inputs();
            key_valid = (c >= 5 && c <= 7);
            key_code  = (c == 5) ? 8'h11 : (c == 6) ? 8'h22 : 8'h33;
            iret_seen = (c == 15 || c == 25);
            @(negedge clock);
            exp_ctrl = {(c >= 6 && c <= 10) || (c >= 18 && c <= 22),
                        (c >= 6 && c <= 9)  || (c >= 18 && c <= 21),
                        (c >= 11 && c <= 15) || (c >= 23 && c <= 25),
                        c == 16 || c == 26};
            checks++;
            if ({fetch_hold, insert_nop, irq_active, resume_valid} !== exp_ctrl) begin
                failures++;
                $display("FAIL queue_ctrl cycle %0d got %b expected %b", c,
                         {fetch_hold, insert_nop, irq_active, resume_valid}, exp_ctrl);
            end
            if (c == 12 || c == 30) begin
                checks++;
                if (drop_count !== 8'd1) begin
                    failures++;
                    $display("FAIL queue_drops cycle %0d got %0d expected 1", c, drop_count);
                end
            end
            if (c == 12 || c == 23) begin
                checks++;
                if (key_data !== ((c == 12) ? 8'h11 : 8'h22)) begin
                    failures++;
                    $display("FAIL queue_key_data cycle %0d got %h expected %h", c, key_data,
                             (c == 12) ? 8'h11 : 8'h22);
                end
            end
            if (c == 16 || c == 26) begin
                checks++;
                if (resume_pc !== 32'h1234) begin
                    failures++;
                    $display("FAIL queue_resume_pc cycle %0d got %h expected 00001234", c, resume_pc);
                end
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_drop_saturation();
        do_reset();
        pc_in = 32'd8;
        for (int c = 0; c <= 305; c++) begin
            quiet_inputs();
            key_valid = (c >= 2 && c <= 300);
            key_code  = 8'(c);
            iret_seen = (c == 303);
            @(negedge clock);
            if (c == 200 || c == 305) begin
                checks++;
                if (drop_count !== ((c == 200) ? 8'd196 : 8'd255)) begin
                    failures++;
                    $display("FAIL drop_saturation cycle %0d got %0d expected %0d", c, drop_count,
                             (c == 200) ? 196 : 255);
                end
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset_mid_service();
        do_reset();
        pc_in = 32'h77;
        for (int c = 0; c <= 10; c++) begin
            quiet_inputs();
            key_valid = (c == 2 || c == 8 || c == 9);
            key_code  = 8'h5A;
            @(negedge clock);
            if (c == 10) begin
                checks++;
                if ({fetch_hold, irq_active, drop_count} !== {1'b0, 1'b1, 8'd1}) begin
                    failures++;
                    $display("FAIL midrst_pre hold=%b irq=%b drops=%0d expected 0 1 1",
                             fetch_hold, irq_active, drop_count);
                end
            end
            @(posedge clock);
            #1;
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({fetch_hold, insert_nop, irq_active, resume_valid, interrupt_instruction,
             resume_pc, key_data, drop_count} !== 84'd0) begin
            failures++;
            $display("FAIL midrst_outputs ctrl=%b key=%h drops=%0d expected all 0",
                     {fetch_hold, insert_nop, irq_active, resume_valid}, key_data, drop_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            quiet_inputs();
            iret_seen = (c == 1);
            @(negedge clock);
            checks++;
            if ({fetch_hold, insert_nop, irq_active, resume_valid} !== 4'b0000) begin
                failures++;
                $display("FAIL midrst_after cycle %0d got %b expected 0000", c,
                         {fetch_hold, insert_nop, irq_active, resume_valid});
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_stray_return();
        logic [3:0] exp_ctrl;
        do_reset();
        pc_in = 32'h40;
        for (int c = 0; c <= 18; c++) begin
            quiet_inputs();
            key_valid = (c == 5);
            key_code  = 8'h55;
            iret_seen = (c == 2 || c == 7 || c == 15);
            @(negedge clock);
            exp_ctrl = {c >= 6 && c <= 10, c >= 6 && c <= 9, c >= 11 && c <= 15, c == 16};
            checks++;
            if ({fetch_hold, insert_nop, irq_active, resume_valid} !== exp_ctrl) begin
                failures++;
                $display("FAIL stray_ctrl cycle %0d got %b expected %b", c,
                         {fetch_hold, insert_nop, irq_active, resume_valid}, exp_ctrl);
            end
            @(posedge clock);
            #1;
        end
    endtask

    // Random pipeline noise, PCs, stray returns and extra keys; expectations
    // come from scanning the stimulus for the first run of D quiet cycles.
    task automatic test_random();
        logic        q_busy [80], q_stall [80], q_jump [80], q_key [80], q_iret [80];
        logic [31:0] q_pc [80], q_jt [80];
        logic [7:0]  q_code [80];
        logic [7:0]  code0, first_extra;
        logic [31:0] spc;
        logic [3:0]  exp_ctrl;
        int          run, inj, iret, r, n_extra;
        for (int it = 0; it < 20; it++) begin
            do_reset();
            for (int c = 0; c < 80; c++) begin
                q_busy[c]  = (c < 50) && ($urandom_range(0, 3) == 0);
                q_stall[c] = (c < 50) && ($urandom_range(0, 5) == 0);
                q_jump[c]  = (c < 50) && ($urandom_range(0, 5) == 0);
                q_pc[c]    = $urandom;
                q_jt[c]    = $urandom;
                q_code[c]  = 8'($urandom);
                q_key[c]   = 1'b0;
                q_iret[c]  = 1'b0;
            end
            code0 = 8'($urandom);
            spc = q_pc[3];
            run = 0;
            inj = -1;
            for (int c = 3; c < 80 && inj < 0; c++) begin
                if (q_jump[c]) spc = q_jt[c];
                if (!q_busy[c] && !q_stall[c] && !q_jump[c]) run++;
                else run = 0;
                if (run == D) inj = c + 1;
            end
            iret = inj + 1 + $urandom_range(0, 5);
            r = iret + 1;
            n_extra = 0;
            first_extra = 8'd0;
            for (int c = 0; c < inj; c++) q_iret[c] = ($urandom_range(0, 4) == 0);
            q_iret[iret] = 1'b1;
            for (int c = 3; c <= r; c++) begin
                q_key[c] = ($urandom_range(0, 4) == 0);
                if (q_key[c]) begin
                    if (n_extra == 0) first_extra = q_code[c];
                    n_extra++;
                end
            end
            for (int c = 0; c <= r + 2; c++) begin
                key_valid   = (c == 2) || q_key[c];
                key_code    = (c == 2) ? code0 : q_code[c];
                pc_in       = q_pc[c];
                should_jump = q_jump[c];
                jump_to     = q_jt[c];
                muldiv_busy = q_busy[c];
                stall_in    = q_stall[c];
                iret_seen   = q_iret[c];
                @(negedge clock);
                if (c <= r + 1) begin
                    exp_ctrl = {c >= 3 && c <= inj, c >= 3 && c < inj, c > inj && c <= iret, c == r};
                    checks++;
                    if ({fetch_hold, insert_nop, irq_active, resume_valid} !== exp_ctrl) begin
                        failures++;
                        $display("FAIL rand_ctrl it %0d cycle %0d got %b expected %b", it, c,
                                 {fetch_hold, insert_nop, irq_active, resume_valid}, exp_ctrl);
                    end
                    checks++;
                    if (interrupt_instruction !== ((c == inj) ? INJ : 32'd0)) begin
                        failures++;
                        $display("FAIL rand_instr it %0d cycle %0d got %h", it, c, interrupt_instruction);
                    end
                end
                if (c == inj + 1) begin
                    checks++;
                    if (key_data !== code0) begin
                        failures++;
                        $display("FAIL rand_key_data it %0d got %h expected %h", it, key_data, code0);
                    end
                end
                if (c == r) begin
                    checks++;
                    if (resume_pc !== spc) begin
                        failures++;
                        $display("FAIL rand_resume_pc it %0d got %h expected %h", it, resume_pc, spc);
                    end
                end
                if (c == r + 1) begin
                    checks++;
                    if (drop_count !== 8'((n_extra > 0) ? n_extra - 1 : 0)) begin
                        failures++;
                        $display("FAIL rand_drops it %0d got %0d expected %0d", it, drop_count,
                                 (n_extra > 0) ? n_extra - 1 : 0);
                    end
                end
                if (c == r + 2) begin
                    checks++;
                    if (fetch_hold !== (n_extra > 0)) begin
                        failures++;
                        $display("FAIL rand_requeue it %0d hold got %b expected %b", it, fetch_hold, n_extra > 0);
                    end
                    if (n_extra > 0) begin
                        checks++;
                        if (key_data !== first_extra) begin
                            failures++;
                            $display("FAIL rand_pending_key it %0d got %h expected %h", it, key_data, first_extra);
                        end
                    end
                end
                @(posedge clock);
                #1;
            end
        end
    endtask

    initial begin
        quiet_inputs();
        pc_in = 32'd0;
        test_reset();
        test_basic();
        test_muldiv_drain();
        test_jump_drain();
        test_queue_drop();
        test_drop_saturation();
        test_reset_mid_service();
        test_stray_return();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_interrupt_sequencer.md
# key_interrupt_sequencer

Sequences keyboard interrupts into the fetch stage. It buffers incoming key events and freezes the program counter, then drains the pipeline of in-flight mult/div work and pending jumps. Once drained, it injects a jump to the interrupt handler and later returns fetch to the interrupted PC. It sits beside the fetch stage and drives that stage's key-interrupt/hold, injected-instruction and jump-override inputs.

## Interface
- HANDLER_ADDR, 27'd4000: handler entry, placed in the target field of the injected `j` instruction.
- DRAIN_CYCLES, 4: consecutive quiet cycles required before injection; legal range 1..7.
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe: a key event is present.
- key_code  in  8  key scan code, valid with key_valid.
- pc_in  in  32  current fetch PC.
- should_jump  in  1  a jump resolves this cycle.
- jump_to  in  32  jump target, valid with should_jump.
- muldiv_busy  in  1  a mult/div is in F/D or D/X.
- stall_in  in  1  decode-stage stall.
- iret_seen  in  1  one-cycle pulse: the decoder saw the handler's return instruction.
- fetch_hold  out  1  freeze PC (drives fetch key_interrupt/hold).
- insert_nop  out  1  load a bubble into F/D.
- interrupt_instruction  out  32  injected instruction; 0 when not injecting.
- irq_active  out  1  handler is executing.
- key_data  out  8  scan code of the interrupt being serviced.
- resume_valid  out  1  one-cycle jump-override strobe.
- resume_pc  out  32  return target, valid with resume_valid.
- drop_count  out  8  saturating count of lost key events.

## Operation
- The FSM has five states: IDLE, DRAIN, INJECT, SERVICE, RESUME.
- **IDLE**
  - If a key is pending or key_valid=1, go to DRAIN.
  - key_data loads the pending code if one exists, otherwise key_code.
- **DRAIN**
  - Outputs: fetch_hold=1, insert_nop=1.
  - First DRAIN cycle: saved_pc <= pc_in.
  - Any cycle with should_jump=1: saved_pc <= jump_to. This overrides the first-cycle capture when both happen in the same cycle.
  - A quiet cycle has muldiv_busy=0, stall_in=0 and should_jump=0. quiet_cnt (3 bits) increments on a quiet cycle and clears to 0 otherwise.
  - When quiet_cnt reaches DRAIN_CYCLES, go to INJECT.
- **INJECT** (exactly 1 cycle)
  - Outputs: fetch_hold=1, insert_nop=0.
  - interrupt_instruction = {5'b00001, HANDLER_ADDR}.
  - Go to SERVICE.
- **SERVICE**
  - Outputs: fetch_hold=0, irq_active=1.
  - Wait for iret_seen, then go to RESUME.
- **RESUME** (exactly 1 cycle)
  - Outputs: resume_valid=1, resume_pc=saved_pc, irq_active=0.
  - Go to IDLE.
- **Key buffer** (one entry deep)
  - key_valid outside IDLE: store the code in pending if pending is empty.
  - key_valid while pending is full: drop the event and increment drop_count, saturating at 255.
  - A key consumed in IDLE clears pending.
  - If a pending key and a new key_valid arrive together in IDLE: the pending key is serviced and the new key becomes pending.
- iret_seen outside SERVICE is ignored.

## Timing
- Reset (asynchronous, reset=0) values:
  - state IDLE.
  - All outputs 0: fetch_hold, insert_nop, interrupt_instruction, irq_active, key_data, resume_valid, resume_pc, drop_count.
  - saved_pc, quiet_cnt and pending are cleared.
- Reset during any state aborts the interrupt. No resume is issued and pending keys are lost.
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.
- Latency with no stalls, key_valid high at cycle n:
  - DRAIN for cycles n+1 .. n+DRAIN_CYCLES.
  - INJECT at n+DRAIN_CYCLES+1.
  - SERVICE from n+DRAIN_CYCLES+2.
- iret_seen at cycle m gives resume_valid at m+1 and IDLE at m+2.
- A pending key causes DRAIN to be entered at m+3.
- Busy, stall or jump cycles in DRAIN extend it without bound. There is no timeout.

## Test plan
- **Basic interrupt:** reset, then pc_in=100, key_valid with code 0x1C at cycle 5, no stalls, DRAIN_CYCLES=4.
  - fetch_hold high for cycles 6-10.
  - interrupt_instruction = 0x08000FA0 at cycle 10 only.
  - key_data=0x1C.
  - iret_seen at cycle 20 gives resume_valid=1 and resume_pc=100 at cycle 21.
- **Mult/div drain:** muldiv_busy high for cycles 6-8 after a key at 5.
  - INJECT does not occur before cycle 13.
  - quiet_cnt restarts after cycle 8.
- **Jump during drain:** should_jump=1 with jump_to=0x200 in the third DRAIN cycle.
  - resume_pc=0x200.
  - INJECT is delayed until 4 quiet cycles after the jump.
- **Queueing and drops:** keys 0x11, 0x22, 0x33 on consecutive cycles.
  - 0x11 is serviced; 0x22 is pending; drop_count=1.
  - After RESUME, a second interrupt is serviced with key_data=0x22.
- **Reset mid-SERVICE:** reset=0 while irq_active=1.
  - All outputs are 0 immediately, with no resume_valid.
  - A later iret_seen causes no response.
- **Stray return:** iret_seen in IDLE and in DRAIN.
  - State and outputs unchanged; resume_valid stays 0.
